// File: rtl/irq_claim_ctrl_pkg.sv
// Shared constants for the interrupt claim controller.
// Register offsets, FSM states, STATUS layout.
package irq_claim_ctrl_pkg;

  localparam int IRQ_W_DEF   = 32;
  localparam int IRQ_LSB_DEF = 4;
  localparam int ID_W_DEF    = 5;

  typedef enum logic [1:0] {
    REG_PENDING = 2'd0,
    REG_ENABLE  = 2'd1,
    REG_STATUS  = 2'd2,
    REG_SWSET   = 2'd3
  } reg_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } irq_state_e;

  localparam int STAT_REQ_BIT = 8;

  function automatic logic [31:0] status_word(
    input logic       req,
    input logic [7:0] id
  );
    logic [31:0] w;
    w = '0;
    w[STAT_REQ_BIT] = req;
    w[4:0] = id[4:0];
    return w;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder, lowest set index wins.
// Ports: req (W) in; valid, id (ID_W) out.
module irq_prio_enc
  import irq_claim_ctrl_pkg::*;
#(
  parameter int W    = IRQ_W_DEF,
  parameter int ID_W = ID_W_DEF
) (
  input  logic [W-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scan from the top so the lowest set bit is written last.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_claim_ctrl.sv
// Latches interrupt pulses, masks, prioritises, hands one id to the core.
// Ports: clk_i, rst_n_i, irq_i, irq_req_o/id_o/ack_i, reg port.
module irq_claim_ctrl
  import irq_claim_ctrl_pkg::*;
#(
  parameter int IRQ_W   = IRQ_W_DEF,
  parameter int IRQ_LSB = IRQ_LSB_DEF,
  parameter int ID_W    = ID_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [IRQ_W-1:0] irq_i,
  output logic             irq_req_o,
  output logic [ID_W-1:0]  irq_id_o,
  input  logic             irq_ack_i,
  input  logic [3:0]       addr_i,
  input  logic             wren_i,
  input  logic             rden_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             ready_o
);

  localparam logic [IRQ_W-1:0] SRC_MASK =
    ~((IRQ_W'(1) << IRQ_LSB) - IRQ_W'(1));

  irq_state_e       state;
  logic [IRQ_W-1:0] pending;
  logic [IRQ_W-1:0] enable;
  logic [IRQ_W-1:0] pend_nxt;
  logic [IRQ_W-1:0] en_nxt;
  logic [IRQ_W-1:0] cand;
  logic             cand_vld;
  logic [ID_W-1:0]  cand_id;
  logic             ack_ok;
  logic             still_live;
  logic [31:0]      rd_val;
  reg_sel_e         sel;
  logic             unused_addr;

  assign unused_addr = ^addr_i[1:0];
  assign sel         = reg_sel_e'(addr_i[3:2]);
  assign ack_ok      = (state == ST_REQ) && irq_ack_i;
  assign cand        = pending & enable;

  // Clears first, sets last: a same-cycle event always survives.
  always_comb begin
    pend_nxt = pending;
    if (ack_ok)
      pend_nxt[irq_id_o] = 1'b0;
    if (wren_i && sel == REG_PENDING)
      pend_nxt = pend_nxt & ~wdata_i[IRQ_W-1:0];
    pend_nxt = pend_nxt | irq_i;
    if (wren_i && sel == REG_SWSET)
      pend_nxt = pend_nxt | wdata_i[IRQ_W-1:0];
    pend_nxt = pend_nxt & SRC_MASK;
  end

  always_comb begin
    en_nxt = enable;
    if (wren_i && sel == REG_ENABLE)
      en_nxt = wdata_i[IRQ_W-1:0] & SRC_MASK;
  end

  // Judge withdrawal on the updated state so the request
  // falls in the same cycle the source disappears.
  assign still_live = pend_nxt[irq_id_o] & en_nxt[irq_id_o];

  always_comb begin
    rd_val = '0;
    unique case (sel)
      REG_PENDING: rd_val = 32'(pending);
      REG_ENABLE:  rd_val = 32'(enable);
      REG_STATUS:  rd_val = status_word(irq_req_o, 8'(irq_id_o));
      REG_SWSET:   rd_val = '0;
      default:     rd_val = '0;
    endcase
  end

  irq_prio_enc #(
    .W    (IRQ_W),
    .ID_W (ID_W)
  ) u_enc (
    .req   (cand),
    .valid (cand_vld),
    .id    (cand_id)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending <= '0;
      enable  <= '0;
      rdata_o <= '0;
      ready_o <= 1'b0;
    end else begin
      pending <= pend_nxt;
      enable  <= en_nxt;
      ready_o <= wren_i | rden_i;
      if (rden_i)
        rdata_o <= rd_val;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      irq_req_o <= 1'b0;
      irq_id_o  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cand_vld) begin
            irq_id_o  <= cand_id;
            irq_req_o <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_ok || !still_live) begin
            irq_req_o <= 1'b0;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          irq_req_o <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_claim_ctrl.sv
// Randomised and directed checks of irq_claim_ctrl
// against a behavioural model of pending/enable/claim rules.
module tb_irq_claim_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq;
  logic        req;
  logic [4:0]  id;
  logic        ack;
  logic [3:0]  addr;
  logic        wren;
  logic        rden;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  irq_claim_ctrl dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .irq_i     (irq),
    .irq_req_o (req),
    .irq_id_o  (id),
    .irq_ack_i (ack),
    .addr_i    (addr),
    .wren_i    (wren),
    .rden_i    (rden),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .ready_o   (ready)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] MASK = 32'hFFFF_FFF0;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  logic [31:0] m_pend, m_en, m_rdata;
  logic        m_req, m_gap, m_ready;
  logic [4:0]  m_id;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_rdata = '0;
    m_req = 0; m_gap = 0; m_ready = 0; m_id = '0;
  endtask

  function automatic logic [4:0] lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++)
      if (v[i]) return 5'(i);
    return 5'd0;
  endfunction

  task automatic model_step(input logic [31:0] i_irq, input logic i_ack,
                            input logic i_wr, input logic i_rd,
                            input logic [3:0] i_addr,
                            input logic [31:0] i_wd);
    logic [31:0] np, ne, cand;
    logic [1:0]  r;
    r = i_addr[3:2];
    cand = m_pend & m_en;
    np = m_pend;
    if (m_req && i_ack) np[m_id] = 1'b0;
    if (i_wr && r == 2'd0) np = np & ~i_wd;
    np = np | i_irq;
    if (i_wr && r == 2'd3) np = np | i_wd;
    np = np & MASK;
    ne = (i_wr && r == 2'd1) ? (i_wd & MASK) : m_en;
    if (i_rd) begin
      case (r)
        2'd0: m_rdata = m_pend;
        2'd1: m_rdata = m_en;
        2'd2: m_rdata = (32'(m_req) << 8) | 32'(m_id);
        default: m_rdata = 32'h0;
      endcase
    end
    m_ready = i_wr | i_rd;
    if (m_req) begin
      if (i_ack || !(np[m_id] && ne[m_id])) begin
        m_req = 0;
        m_gap = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (cand != 0) begin
      m_id = lowest(cand);
      m_req = 1;
    end
    m_pend = np;
    m_en = ne;
  endtask

  task automatic compare_all();
    chk("req", 32'(req), 32'(m_req));
    chk("id", 32'(id), 32'(m_id));
    chk("ready", 32'(ready), 32'(m_ready));
    chk("rdata", rdata, m_rdata);
  endtask

  // One cycle: drive after a falling edge, check at the next one.
  task automatic step(input logic [31:0] i_irq, input logic i_ack,
                      input logic i_wr, input logic i_rd,
                      input logic [3:0] i_addr,
                      input logic [31:0] i_wd);
    irq = i_irq; ack = i_ack; wren = i_wr; rden = i_rd;
    addr = i_addr; wdata = i_wd;
    model_step(i_irq, i_ack, i_wr, i_rd, i_addr, i_wd);
    @(negedge clk);
    irq = '0; ack = 0; wren = 0; rden = 0; addr = '0; wdata = '0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 0, 0, 0, 4'h0, '0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    step('0, 0, 1, 0, a, d);
  endtask

  task automatic rd(input logic [3:0] a);
    step('0, 0, 0, 1, a, '0);
  endtask

  task automatic do_ack();
    step('0, 1, 0, 0, 4'h0, '0);
  endtask

  initial begin
    irq = '0; ack = 0; wren = 0; rden = 0; addr = '0; wdata = '0;
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    compare_all();
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_rdata", rdata, 32'h0);

    // Single source end to end
    wr(4'h4, 32'h0000_0010);
    step(32'h10, 0, 0, 0, 4'h0, '0);
    rd(4'h0);
    chk("t1_pend", rdata, 32'h10);
    chk("t1_req", 32'(req), 32'h1);
    chk("t1_id", 32'(id), 32'h4);
    do_ack();
    chk("t1_drop", 32'(req), 32'h0);
    rd(4'h0);
    chk("t1_pend0", rdata, 32'h0);
    idle(2);

    // Priority, gap, frozen id
    wr(4'h4, 32'hFFFF_FFF0);
    step(32'h240, 0, 0, 0, 4'h0, '0);
    idle(1);
    chk("t2_id6", 32'(id), 32'h6);
    do_ack();
    chk("t2_gap", 32'(req), 32'h0);
    idle(1);
    chk("t2_gap2", 32'(req), 32'h0);
    idle(1);
    chk("t2_id9", 32'(id), 32'h9);
    step(32'h20, 0, 0, 0, 4'h0, '0);
    idle(2);
    chk("t2_frozen", 32'(id), 32'h9);
    do_ack();
    idle(2);
    chk("t2_id5", 32'(id), 32'h5);
    do_ack();
    idle(2);

    // Reserved low bits never latch
    wr(4'h4, 32'hFFFF_FFFF);
    step(32'hF, 0, 0, 0, 4'h0, '0);
    idle(2);
    chk("t3_noreq", 32'(req), 32'h0);
    rd(4'h0);
    chk("t3_pend", rdata, 32'h0);

    // Withdrawal by W1C, then W1C plus ack
    step(32'h80, 0, 0, 0, 4'h0, '0);
    idle(1);
    chk("t4_id7", 32'(id), 32'h7);
    wr(4'h0, 32'h80);
    chk("t4_wdraw", 32'(req), 32'h0);
    idle(2);
    step(32'h80, 0, 0, 0, 4'h0, '0);
    idle(1);
    step('0, 1, 1, 0, 4'h0, 32'h80);
    chk("t4_ackw", 32'(req), 32'h0);
    idle(2);

    // Set beats clear, SWSET, STATUS
    step(32'h100, 0, 1, 0, 4'h0, 32'h100);
    rd(4'h0);
    chk("t5_keep", rdata, 32'h100);
    do_ack();
    idle(2);
    wr(4'hC, 32'h100);
    idle(1);
    rd(4'h8);
    chk("t5_stat", rdata, 32'h108);
    rd(4'hC);
    chk("t5_swrd", rdata, 32'h0);
    do_ack();
    idle(2);

    // Asynchronous reset mid-request
    step(32'h400, 0, 0, 0, 4'h0, '0);
    idle(1);
    chk("t6_req", 32'(req), 32'h1);
    #2 rst_n = 0;
    #1;
    chk("t6_areq", 32'(req), 32'h0);
    chk("t6_aid", 32'(id), 32'h0);
    chk("t6_ardy", 32'(ready), 32'h0);
    chk("t6_ardata", rdata, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    rd(4'h4);
    chk("t6_en0", rdata, 32'h0);
    wr(4'h4, 32'h0000_1000);
    step(32'h1000, 0, 0, 0, 4'h0, '0);
    idle(1);
    chk("t6_post", 32'(id), 32'hC);
    do_ack();
    idle(2);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r_irq, r_wd;
      logic        r_ack, r_wr, r_rd;
      logic [3:0]  r_a;
      r_irq = ($urandom_range(0, 3) == 0) ? (32'd1 << $urandom_range(0, 31)) : '0;
      if ($urandom_range(0, 15) == 0) r_irq = r_irq | $urandom;
      r_ack = ($urandom_range(0, 3) == 0);
      r_wr  = ($urandom_range(0, 5) == 0);
      r_rd  = ($urandom_range(0, 2) == 0);
      r_a   = 4'($urandom_range(0, 15));
      r_wd  = ($urandom_range(0, 1) == 0) ? $urandom : (32'd1 << $urandom_range(0, 31));
      step(r_irq, r_ack, r_wr, r_rd, r_a, r_wd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
